// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and constants for the UART transmit path
package uart_tx_pkg;

  localparam int UART_DATA_BITS     = 8;
  localparam int UART_TX_FIFO_DEPTH = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO with first-word-fall-through read
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = UART_TX_FIFO_DEPTH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves on the same edge
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (do_push && reset && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: TX FIFO plus frame serialiser and baud timing
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = UART_TX_FIFO_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tx_fifo_wr_en,
  input  logic [7:0]  tx_fifo_data,
  input  logic        uart_en,
  input  logic        tx_en,
  input  logic        parity_enable,
  input  logic        parity,
  input  logic        stop_bit,
  input  logic [15:0] baud_rate,
  output logic        tx,
  output logic        tx_fifo_full,
  output logic        tx_fifo_empty,
  output logic        tx_overflow,
  output logic        busy
);

  uart_tx_state_t            state;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [2:0]                bit_idx;
  logic [15:0]               baud_cnt;
  logic [15:0]               div;
  logic                      par_en;
  logic                      par_bit;
  logic                      two_stop;
  logic                      stop_second;
  logic [7:0]                fifo_rdata;
  logic                      bit_end;
  logic                      frame_done;
  logic                      start_ok;
  logic                      pop;

  assign bit_end    = (baud_cnt == div - 16'd1);
  assign frame_done = (state == STOP) && bit_end && (!two_stop || stop_second);
  assign start_ok   = uart_en && tx_en && !tx_fifo_empty;
  assign pop        = start_ok && ((state == IDLE) || frame_done);
  assign busy       = (state != IDLE) || !tx_fifo_empty;

  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (!uart_en),
    .push  (tx_fifo_wr_en && uart_en),
    .pop   (pop),
    .wdata (tx_fifo_data),
    .rdata (fifo_rdata),
    .full  (tx_fifo_full),
    .empty (tx_fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      tx          <= 1'b1;
      baud_cnt    <= '0;
      shreg       <= '0;
      bit_idx     <= '0;
      div         <= 16'd1;
      par_en      <= 1'b0;
      par_bit     <= 1'b0;
      two_stop    <= 1'b0;
      stop_second <= 1'b0;
      tx_overflow <= 1'b0;
    end else if (!uart_en) begin
      state       <= IDLE;
      tx          <= 1'b1;
      baud_cnt    <= '0;
      stop_second <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      tx_overflow <= tx_fifo_wr_en && tx_fifo_full && !pop;
      if (pop) begin
        // Frame settings are captured here so mid-frame CTRL writes wait for the next byte
        shreg       <= fifo_rdata;
        par_en      <= parity_enable;
        par_bit     <= (^fifo_rdata) ^ parity;
        two_stop    <= stop_bit;
        div         <= (baud_rate == 16'd0) ? 16'd1 : baud_rate;
        state       <= START;
        tx          <= 1'b0;
        baud_cnt    <= '0;
        bit_idx     <= '0;
        stop_second <= 1'b0;
      end else if (state == IDLE) begin
        tx <= 1'b1;
      end else if (!bit_end) begin
        baud_cnt <= baud_cnt + 16'd1;
      end else begin
        baud_cnt <= '0;
        case (state)
          START: begin
            state <= DATA;
            tx    <= shreg[0];
          end
          DATA: begin
            if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
              state <= par_en ? PARITY : STOP;
              tx    <= par_en ? par_bit : 1'b1;
            end else begin
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
          PARITY: begin
            state <= STOP;
            tx    <= 1'b1;
          end
          STOP: begin
            tx <= 1'b1;
            if (two_stop && !stop_second) stop_second <= 1'b1;
            else                          state       <= IDLE;
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
